// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_LINE_WIDTH     = 128;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_R = 2'd1,
    WAIT_W = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    M0_R = 2'd1,
    M1_R = 2'd2,
    M1_W = 2'd3
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the line-wide data-memory port.
// M1 writes have priority; the two readers share the port round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned LINE_WIDTH     = DEF_LINE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_r_req_valid,
  output logic                  m0_r_req_ready,
  input  logic [ADDR_WIDTH-1:0] m0_r_req_addr,
  output logic                  m0_r_rep_valid,
  output logic [LINE_WIDTH-1:0] m0_r_rep_data,
  input  logic                  m1_r_req_valid,
  output logic                  m1_r_req_ready,
  input  logic [ADDR_WIDTH-1:0] m1_r_req_addr,
  output logic                  m1_r_rep_valid,
  output logic [LINE_WIDTH-1:0] m1_r_rep_data,
  input  logic                  m1_w_req_valid,
  output logic                  m1_w_req_ready,
  input  logic [ADDR_WIDTH-1:0] m1_w_req_addr,
  input  logic [LINE_WIDTH-1:0] m1_w_req_data,
  output logic                  m1_w_rep_valid,
  output logic                  s_r_req_valid,
  input  logic                  s_r_req_ready,
  output logic [ADDR_WIDTH-1:0] s_r_req_addr,
  input  logic                  s_r_rep_valid,
  input  logic [LINE_WIDTH-1:0] s_r_rep_data,
  output logic                  s_w_req_valid,
  input  logic                  s_w_req_ready,
  output logic [ADDR_WIDTH-1:0] s_w_req_addr,
  output logic [LINE_WIDTH-1:0] s_w_req_data,
  input  logic                  s_w_rep_valid,
  output logic                  busy,
  output logic [1:0]            owner,
  output logic                  timeout_err
);

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  arb_state_t       state_q, state_d;
  arb_owner_t       owner_q, owner_d;
  logic             rr_q, rr_d;          // 0: M0 favoured, 1: M1 favoured
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             gnt_w, gnt_r0, gnt_r1;
  logic             idle;
  logic [CNT_W-1:0] cnt_inc;
  logic             wd_fire;

  assign idle = (state_q == IDLE);

  // Grant selection: write first, then the round-robin favourite, then a lone reader.
  always_comb begin
    gnt_w  = m1_w_req_valid;
    gnt_r0 = !m1_w_req_valid && m0_r_req_valid && (!m1_r_req_valid || !rr_q);
    gnt_r1 = !m1_w_req_valid && m1_r_req_valid && (!m0_r_req_valid ||  rr_q);
  end

  // Request forwarding; both downstream address buses carry the granted master's address.
  always_comb begin
    s_r_req_valid  = idle && (gnt_r0 || gnt_r1);
    s_w_req_valid  = idle && gnt_w;
    m0_r_req_ready = idle && gnt_r0 && s_r_req_ready;
    m1_r_req_ready = idle && gnt_r1 && s_r_req_ready;
    m1_w_req_ready = idle && gnt_w  && s_w_req_ready;
    if (gnt_w) begin
      s_r_req_addr = m1_w_req_addr;
    end else if (gnt_r1) begin
      s_r_req_addr = m1_r_req_addr;
    end else begin
      s_r_req_addr = m0_r_req_addr;
    end
    s_w_req_addr = s_r_req_addr;
    s_w_req_data = m1_w_req_data;
  end

  // Reply routing; a reply in the reset cycle or on the wrong channel is dropped.
  always_comb begin
    m0_r_rep_data  = s_r_rep_data;
    m1_r_rep_data  = s_r_rep_data;
    m0_r_rep_valid = !rst && (state_q == WAIT_R) && (owner_q == M0_R) && s_r_rep_valid;
    m1_r_rep_valid = !rst && (state_q == WAIT_R) && (owner_q == M1_R) && s_r_rep_valid;
    m1_w_rep_valid = !rst && (state_q == WAIT_W) && s_w_rep_valid;
  end

  // Watchdog increment, saturating at the limit; fires on the cycle it reaches the limit.
  always_comb begin
    cnt_inc = (cnt_q == T_LIM) ? cnt_q : cnt_q + 1'b1;
    wd_fire = WD_ON && (cnt_inc == T_LIM);
  end

  // Next-state, owner, round-robin pointer and watchdog logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s_w_req_valid && s_w_req_ready) begin
          state_d = WAIT_W;
          owner_d = M1_W;
        end else if (s_r_req_valid && s_r_req_ready) begin
          state_d = WAIT_R;
          owner_d = gnt_r1 ? M1_R : M0_R;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_inc;
        if (s_r_rep_valid) begin
          state_d = IDLE;
          owner_d = NONE;
          rr_d    = (owner_q == M0_R);
        end else if (wd_fire) begin
          state_d = IDLE;
          owner_d = NONE;
          err_d   = 1'b1;
        end
      end
      WAIT_W: begin
        cnt_d = cnt_inc;
        if (s_w_rep_valid) begin
          state_d = IDLE;
          owner_d = NONE;
        end else if (wd_fire) begin
          state_d = IDLE;
          owner_d = NONE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= NONE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy        = !idle;
  assign owner       = owner_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_r_req_valid, m0_r_req_ready, m0_r_rep_valid;
  logic [AW-1:0] m0_r_req_addr;
  logic [LW-1:0] m0_r_rep_data;
  logic          m1_r_req_valid, m1_r_req_ready, m1_r_rep_valid;
  logic [AW-1:0] m1_r_req_addr;
  logic [LW-1:0] m1_r_rep_data;
  logic          m1_w_req_valid, m1_w_req_ready, m1_w_rep_valid;
  logic [AW-1:0] m1_w_req_addr;
  logic [LW-1:0] m1_w_req_data;
  logic          s_r_req_valid, s_r_req_ready, s_r_rep_valid;
  logic [AW-1:0] s_r_req_addr;
  logic [LW-1:0] s_r_rep_data;
  logic          s_w_req_valid, s_w_req_ready, s_w_rep_valid;
  logic [AW-1:0] s_w_req_addr;
  logic [LW-1:0] s_w_req_data;
  logic          busy, timeout_err;
  logic [1:0]    owner;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_WIDTH(LW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_r_req_valid(m0_r_req_valid), .m0_r_req_ready(m0_r_req_ready),
    .m0_r_req_addr(m0_r_req_addr), .m0_r_rep_valid(m0_r_rep_valid),
    .m0_r_rep_data(m0_r_rep_data),
    .m1_r_req_valid(m1_r_req_valid), .m1_r_req_ready(m1_r_req_ready),
    .m1_r_req_addr(m1_r_req_addr), .m1_r_rep_valid(m1_r_rep_valid),
    .m1_r_rep_data(m1_r_rep_data),
    .m1_w_req_valid(m1_w_req_valid), .m1_w_req_ready(m1_w_req_ready),
    .m1_w_req_addr(m1_w_req_addr), .m1_w_req_data(m1_w_req_data),
    .m1_w_rep_valid(m1_w_rep_valid),
    .s_r_req_valid(s_r_req_valid), .s_r_req_ready(s_r_req_ready),
    .s_r_req_addr(s_r_req_addr), .s_r_rep_valid(s_r_rep_valid),
    .s_r_rep_data(s_r_rep_data),
    .s_w_req_valid(s_w_req_valid), .s_w_req_ready(s_w_req_ready),
    .s_w_req_addr(s_w_req_addr), .s_w_req_data(s_w_req_data),
    .s_w_rep_valid(s_w_rep_valid),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and step just past the edge; inputs change here, checks follow a #1 settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [LW-1:0] line_a5;
  logic [LW-1:0] rdata;
  logic          exp_m1;

  initial begin
    line_a5 = {16{8'hA5}};
    rst = 1'b1;
    m0_r_req_valid = 1'b0; m0_r_req_addr = '0;
    m1_r_req_valid = 1'b0; m1_r_req_addr = '0;
    m1_w_req_valid = 1'b0; m1_w_req_addr = '0; m1_w_req_data = '0;
    s_r_req_ready = 1'b1; s_r_rep_valid = 1'b0; s_r_rep_data = '0;
    s_w_req_ready = 1'b1; s_w_rep_valid = 1'b0;

    // Reset state
    tick(); tick();
    settle();
    chk("rst_busy", busy, 1'b0);
    chk_o("rst_owner", owner, 2'd0);
    chk("rst_err", timeout_err, 1'b0);
    chk("rst_m0_ready", m0_r_req_ready, 1'b0);
    chk("rst_s_r_valid", s_r_req_valid, 1'b0);
    rst = 1'b0;

    // Lone M0 read of 0x10
    tick();
    m0_r_req_valid = 1'b1; m0_r_req_addr = 32'h10;
    settle();
    chk("t1_s_r_valid", s_r_req_valid, 1'b1);
    chk_a("t1_s_r_addr", s_r_req_addr, 32'h10);
    chk("t1_m0_ready", m0_r_req_ready, 1'b1);
    chk("t1_m1_ready", m1_r_req_ready, 1'b0);
    chk("t1_s_w_valid", s_w_req_valid, 1'b0);
    tick();
    m0_r_req_valid = 1'b0;
    s_w_rep_valid = 1'b1;  // wrong-channel reply while waiting on a read
    settle();
    chk("t1_busy_c1", busy, 1'b1);
    chk_o("t1_owner", owner, 2'd1);
    chk("t1_wrong_chan", m1_w_rep_valid, 1'b0);
    chk("t1_wait_s_r_valid", s_r_req_valid, 1'b0);
    tick();
    s_w_rep_valid = 1'b0;
    s_r_rep_valid = 1'b1; s_r_rep_data = line_a5;
    settle();
    chk("t1_busy_c2", busy, 1'b1);
    chk("t1_m0_rep_valid", m0_r_rep_valid, 1'b1);
    chk_d("t1_m0_rep_data", m0_r_rep_data, line_a5);
    chk("t1_m1_rep_valid", m1_r_rep_valid, 1'b0);
    tick();
    s_r_rep_valid = 1'b0;
    settle();
    chk("t1_busy_done", busy, 1'b0);
    chk_o("t1_owner_done", owner, 2'd0);

    // Both readers from reset: grants alternate M0, M1, M0, M1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_r_req_valid = 1'b1; m0_r_req_addr = 32'h100;
    m1_r_req_valid = 1'b1; m1_r_req_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp_m1 = (i % 2 == 1);
      rdata = {4{32'hC0DE_0000 + 32'(i)}};
      settle();
      chk("rr_m0_ready", m0_r_req_ready, !exp_m1);
      chk("rr_m1_ready", m1_r_req_ready, exp_m1);
      chk_a("rr_addr", s_r_req_addr, exp_m1 ? 32'h200 : 32'h100);
      tick();
      settle();
      chk_o("rr_owner", owner, exp_m1 ? 2'd2 : 2'd1);
      chk("rr_loser_ready", exp_m1 ? m0_r_req_ready : m1_r_req_ready, 1'b0);
      tick();
      s_r_rep_valid = 1'b1; s_r_rep_data = rdata;
      settle();
      chk("rr_m0_rep", m0_r_rep_valid, !exp_m1);
      chk("rr_m1_rep", m1_r_rep_valid, exp_m1);
      chk_d("rr_data", exp_m1 ? m1_r_rep_data : m0_r_rep_data, rdata);
      tick();
      s_r_rep_valid = 1'b0;
    end
    m1_r_req_valid = 1'b0;
    m0_r_req_valid = 1'b0;

    // M1 write wins over a concurrent M0 read
    m1_w_req_valid = 1'b1; m1_w_req_addr = 32'h20; m1_w_req_data = 128'h1234;
    m0_r_req_valid = 1'b1; m0_r_req_addr = 32'h10;
    settle();
    chk("w_s_w_valid", s_w_req_valid, 1'b1);
    chk_a("w_s_w_addr", s_w_req_addr, 32'h20);
    chk_d("w_s_w_data", s_w_req_data, 128'h1234);
    chk("w_m1_w_ready", m1_w_req_ready, 1'b1);
    chk("w_m0_ready", m0_r_req_ready, 1'b0);
    chk("w_s_r_valid", s_r_req_valid, 1'b0);
    tick();
    m1_w_req_valid = 1'b0;
    settle();
    chk_o("w_owner", owner, 2'd3);
    chk("w_wait_m0_ready", m0_r_req_ready, 1'b0);
    tick();
    s_w_rep_valid = 1'b1;
    settle();
    chk("w_rep_valid", m1_w_rep_valid, 1'b1);
    chk("w_s_r_valid_in_wait", s_r_req_valid, 1'b0);
    tick();
    s_w_rep_valid = 1'b0;
    settle();
    chk("w_then_r_valid", s_r_req_valid, 1'b1);
    chk_a("w_then_r_addr", s_r_req_addr, 32'h10);
    chk("w_then_m0_ready", m0_r_req_ready, 1'b1);
    tick();
    m0_r_req_valid = 1'b0;
    tick();
    s_r_rep_valid = 1'b1;
    settle();
    chk("w_then_m0_rep", m0_r_rep_valid, 1'b1);
    tick();
    s_r_rep_valid = 1'b0;

    // Watchdog: M1 read with no reply for 8 wait cycles
    m1_r_req_valid = 1'b1; m1_r_req_addr = 32'h300;
    settle();
    chk("wd_m1_ready", m1_r_req_ready, 1'b1);
    tick();
    m1_r_req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("wd_busy_wait", busy, 1'b1);
      chk("wd_err_low", timeout_err, 1'b0);
      tick();
    end
    settle();
    chk("wd_busy_after", busy, 1'b0);
    chk("wd_err_set", timeout_err, 1'b1);
    chk_o("wd_owner", owner, 2'd0);
    tick();
    s_r_rep_valid = 1'b1;
    settle();
    chk("wd_stray_m1", m1_r_rep_valid, 1'b0);
    chk("wd_stray_m0", m0_r_rep_valid, 1'b0);
    tick();
    s_r_rep_valid = 1'b0;
    settle();
    chk("wd_err_sticky", timeout_err, 1'b1);
    chk("wd_idle_kept", busy, 1'b0);

    // rst during WAIT_R with a simultaneous reply
    m0_r_req_valid = 1'b1; m0_r_req_addr = 32'h40;
    tick();
    m0_r_req_valid = 1'b0;
    settle();
    chk("rw_busy", busy, 1'b1);
    rst = 1'b1; s_r_rep_valid = 1'b1;
    settle();
    chk("rw_rep_dropped", m0_r_rep_valid, 1'b0);
    tick();
    rst = 1'b0; s_r_rep_valid = 1'b0;
    settle();
    chk("rw_busy_after", busy, 1'b0);
    chk_o("rw_owner_after", owner, 2'd0);
    chk("rw_err_cleared", timeout_err, 1'b0);

    // Replies in IDLE are ignored
    tick();
    s_r_rep_valid = 1'b1; s_w_rep_valid = 1'b1;
    settle();
    chk("idle_m0_rep", m0_r_rep_valid, 1'b0);
    chk("idle_m1_rep", m1_r_rep_valid, 1'b0);
    chk("idle_w_rep", m1_w_rep_valid, 1'b0);
    tick();
    s_r_rep_valid = 1'b0; s_w_rep_valid = 1'b0;
    settle();
    chk("idle_busy", busy, 1'b0);
    chk_o("idle_owner", owner, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single 128-bit data-memory port (read and write request/reply channels) between the instruction-cache refill engine (M0, read-only) and the data-cache controller (M1, read refill and dirty-line writeback). Sits between the two L1 caches and the line-wide DRAM model inside the memory subsystem. Allows one outstanding transaction at a time. Adds zero cycles on the request path, and uses round-robin fairness between the two readers.

## Interface
- ADDR_WIDTH, 32, line address width carried on all request channels
- LINE_WIDTH, 128, data width of one cache line
- TIMEOUT_CYCLES, 64, cycles allowed in a wait state before the error is flagged; 0 disables the watchdog
- Reset is `rst`, synchronous, active-high. Clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_r_req_valid / m0_r_req_ready  in/out  1  M0 read request handshake
- m0_r_req_addr  in  ADDR_WIDTH  M0 read line address
- m0_r_rep_valid  out  1  M0 read reply strobe
- m0_r_rep_data  out  LINE_WIDTH  M0 read reply line
- m1_r_req_valid / m1_r_req_ready  in/out  1  M1 read request handshake
- m1_r_req_addr  in  ADDR_WIDTH  M1 read line address
- m1_r_rep_valid  out  1  M1 read reply strobe
- m1_r_rep_data  out  LINE_WIDTH  M1 read reply line
- m1_w_req_valid / m1_w_req_ready  in/out  1  M1 write request handshake
- m1_w_req_addr  in  ADDR_WIDTH  M1 write line address
- m1_w_req_data  in  LINE_WIDTH  M1 write line data
- m1_w_rep_valid  out  1  M1 write completion strobe
- s_r_req_valid / s_r_req_ready  out/in  1  downstream read request handshake
- s_r_req_addr  out  ADDR_WIDTH  downstream read address
- s_r_rep_valid  in  1  downstream read reply strobe
- s_r_rep_data  in  LINE_WIDTH  downstream read reply line
- s_w_req_valid / s_w_req_ready  out/in  1  downstream write request handshake
- s_w_req_addr, s_w_req_data  out  ADDR_WIDTH, LINE_WIDTH  downstream write address and data
- s_w_rep_valid  in  1  downstream write completion strobe
- busy  out  1  a transaction is outstanding
- owner  out  2  outstanding requester: 0 = none, 1 = M0 read, 2 = M1 read, 3 = M1 write
- timeout_err  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, WAIT_R, WAIT_W.
- In IDLE, the grant is selected combinationally:
  - If m1_w_req_valid is high, the M1 write wins.
  - Otherwise, among the valid readers, the one the round-robin pointer `rr` favours wins.
  - A lone valid reader wins regardless of `rr`.
- The granted request's valid, addr and data are forwarded to the matching s_* channel. Only the granted master's ready equals the downstream ready; every other ready is 0.
- The other s_* request channel carries valid = 0. Its addr and data are don't-care but are driven from the granted master.
- On a read handshake: latch the owner, go to WAIT_R. On a write handshake: go to WAIT_W.
- In WAIT_R/WAIT_W, all master readies and both s_*_req_valid outputs are 0.
- Replies:
  - s_r_rep_data is passed to both mN_r_rep_data combinationally.
  - s_r_rep_valid is routed only to the owner's rep_valid.
  - s_w_rep_valid maps to m1_w_rep_valid.
  - Either reply returns the FSM to IDLE in the next cycle.
- After a read completes, `rr` points to the other reader. Writes do not change `rr`.
- Replies arriving in IDLE, or on the channel that does not match the current wait state, are ignored and not forwarded.
- Watchdog: a counter clears on entry to a wait state and increments each wait cycle, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES ≠ 0), set timeout_err and force IDLE.
  - Any late reply is then ignored.
  - timeout_err clears only on rst.

## Timing
- Reset values: FSM = IDLE, rr = M0, owner = 0, busy = 0, timeout_err = 0, counter = 0. All readies and rep_valids are 0 unless the combinational rules above drive them.
- Request path latency is 0: master valid reaches s_* valid in the same cycle.
- Reply path latency is 0.
- Back-to-back issue: a new grant is possible in the cycle after the reply cycle, giving a minimum of 3 cycles per read with the current DRAM model (accept, done, reply).
- Simultaneous events:
  - An M1 write and both reads valid in IDLE: the write is granted; the reads hold.
  - A reply and rst in the same cycle: rst wins and the reply is dropped.
- Reset mid-transaction returns to IDLE. Masters must re-request.
- busy = (state != IDLE). owner is registered.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` (IDLE, WAIT_R, WAIT_W)
  - owner encoding `arb_owner_t` (NONE, M0_R, M1_R, M1_W)
  - default widths
- Single module, no sub-modules; the watchdog counter is inline.

## Test plan
- Only M0 reads addr 0x10 with downstream data 0xA5..A5: one s_r handshake → m0_r_rep_valid pulse with that data; m1_r_rep_valid stays 0; busy high for 2 cycles.
- M0 and M1 read valid together from reset: M0 is granted first, M1 next, M0 after that (alternating over 4 transactions); the loser's ready stays 0 while it waits.
- M1 write (addr 0x20, data 0x1234) together with M0 read: the write is issued first and m1_w_rep_valid pulses; the M0 read is issued in the cycle after the write reply.
- Downstream never replies with TIMEOUT_CYCLES=8: timeout_err rises after 8 wait cycles, the FSM returns to IDLE, and a later stray s_r_rep_valid is not forwarded.
- rst asserted in WAIT_R: the next cycle shows busy=0 and owner=0; a reply in the same cycle as rst produces no rep_valid.
- s_r_rep_valid injected in IDLE: no master rep_valid and no state change.
